// File: rtl/mips_imem_pkg.sv
// Shared types and constants for the banked, run-time loadable MIPS instruction memory.
package mips_imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/imem_bank_ram.sv
// One program bank: synchronous write port plus a registered read port that holds its
// value between reads so the fetch output stays stable while the core stalls.
module imem_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Contents are not reset here; the top level zero-clears every word after reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Multi-bank instruction memory: clear-after-reset FSM, valid/ready program loader and a
// registered 1-cycle fetch path that keeps serving other banks while one bank is loading.
module instr_mem_banked
  import mips_imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 64,
  parameter int BANKS  = 4,
  parameter int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [BANK_W-1:0] load_bank,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_trunc,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

  imem_state_e       state_q, state_d;
  logic [BANK_W-1:0] clr_bank_q, clr_bank_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [BANK_W-1:0] load_bank_q, load_bank_d;
  logic              load_done_q, load_done_d;
  logic              load_trunc_q, load_trunc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic              rd_err_q, rd_err_d;

  logic              base_ok;
  logic              fetch_in_range;
  logic              fetch_ok;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BANKS-1:0]  bank_we;
  logic [BANKS-1:0]  bank_re;
  logic [DATA_W-1:0] bank_rdata [BANKS];

  assign base_ok        = ({1'b0, load_base} < DEPTH_L);
  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);

  always_comb begin
    state_d      = state_q;
    clr_bank_d   = clr_bank_q;
    clr_idx_d    = clr_idx_q;
    ptr_d        = ptr_q;
    load_bank_d  = load_bank_q;
    load_done_d  = 1'b0;
    load_trunc_d = 1'b0;
    case (state_q)
      CLEAR: begin
        if (clr_idx_q == LAST_IDX) begin
          clr_idx_d = '0;
          if (clr_bank_q == LAST_BANK) begin
            state_d = IDLE;
          end else begin
            clr_bank_d = clr_bank_q + BANK_W'(1);
          end
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (load_start && base_ok) begin
          state_d     = LOAD;
          load_bank_d = load_bank;
          ptr_d       = load_base[IDX_W-1:0];
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (load_last) begin
            state_d     = IDLE;
            load_done_d = 1'b1;
          end else if (ptr_q == LAST_IDX) begin
            // The pointer never wraps: running off the end of the bank ends the load.
            state_d      = IDLE;
            load_done_d  = 1'b1;
            load_trunc_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_bank = '0;
    wr_idx  = '0;
    wr_data = '0;
    if (state_q == CLEAR) begin
      wr_en   = reset_n;
      wr_bank = clr_bank_q;
      wr_idx  = clr_idx_q;
    end else if (state_q == LOAD) begin
      wr_en   = reset_n && load_valid;
      wr_bank = load_bank_q;
      wr_idx  = ptr_q;
      wr_data = load_data;
    end
  end

  // A fetch into the bank being loaded is dropped; the core keeps requesting while busy.
  always_comb begin
    fetch_ok = fetch_req && reset_n &&
               ((state_q == IDLE) || ((state_q == LOAD) && (bank_sel != load_bank_q)));
    fetch_valid_d = fetch_ok;
    fetch_err_d   = fetch_ok && !fetch_in_range;
    rd_bank_d     = fetch_ok ? bank_sel : rd_bank_q;
    rd_err_d      = fetch_ok ? !fetch_in_range : rd_err_q;
    bank_we       = '0;
    bank_re       = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_we[b] = wr_en && (wr_bank == BANK_W'(b));
      bank_re[b] = fetch_ok && fetch_in_range && (bank_sel == BANK_W'(b));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= CLEAR;
      clr_bank_q    <= '0;
      clr_idx_q     <= '0;
      ptr_q         <= '0;
      load_bank_q   <= '0;
      load_done_q   <= 1'b0;
      load_trunc_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      rd_bank_q     <= '0;
      rd_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_bank_q    <= clr_bank_d;
      clr_idx_q     <= clr_idx_d;
      ptr_q         <= ptr_d;
      load_bank_q   <= load_bank_d;
      load_done_q   <= load_done_d;
      load_trunc_q  <= load_trunc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      rd_bank_q     <= rd_bank_d;
      rd_err_q      <= rd_err_d;
    end
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    imem_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
    ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (bank_we[g]),
      .waddr   (wr_idx),
      .wdata   (wr_data),
      .re      (bank_re[g]),
      .raddr   (fetch_addr[IDX_W-1:0]),
      .rdata   (bank_rdata[g])
    );
  end

  // Bank and error selection only move on an honoured fetch, so the data holds otherwise.
  always_comb begin
    fetch_data = DATA_W'(NOP_INSTR);
    if (!rd_err_q) begin
      for (int b = 0; b < BANKS; b++) begin
        if (rd_bank_q == BANK_W'(b)) begin
          fetch_data = bank_rdata[b];
        end
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign load_ready  = (state_q == LOAD);
  assign load_done   = load_done_q;
  assign load_trunc  = load_trunc_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/instr_mem_banked.md
# instr_mem_banked

Parametrised, multi-bank, run-time loadable instruction memory for the MIPS core. Replaces the fixed-image instruction store: holds `BANKS` independent program images of `DEPTH` words each, zero-clears all banks after reset, and accepts new programs over a valid/ready load port while the core fetches from any other bank. Fetch is registered (1-cycle latency) with an explicit valid flag, so the datapath can stall cleanly during clear and load.

## Interface
- `DATA_W`, 32: instruction word width.
- `ADDR_W`, 10: fetch/load address width.
- `DEPTH`, 64: words per bank; must satisfy `DEPTH <= 2**ADDR_W`.
- `BANKS`, 4: number of program banks, ≥1.
- `BANK_W`, `$clog2(BANKS)` (min 1): bank-select width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `bank_sel` in BANK_W: bank used for fetches.
- `fetch_req` in 1: fetch request, sampled each cycle.
- `fetch_addr` in ADDR_W: word address of the fetch.
- `fetch_valid` out 1: `fetch_data` valid this cycle.
- `fetch_data` out DATA_W: instruction word.
- `fetch_err` out 1: qualifies `fetch_valid`; address was ≥ DEPTH.
- `load_start` in 1: begin a program load (honoured in IDLE only).
- `load_bank` in BANK_W: target bank, latched on `load_start`.
- `load_base` in ADDR_W: first write address, latched on `load_start`.
- `load_valid` in 1: `load_data` present.
- `load_data` in DATA_W: word to write.
- `load_last` in 1: final word of the program.
- `load_ready` out 1: block accepts a load word.
- `load_done` out 1: one-cycle pulse at end of load.
- `load_trunc` out 1: one-cycle pulse with `load_done` when the load ended at `DEPTH-1` without `load_last`.
- `busy` out 1: high in CLEAR and LOAD.

## Operation
- States: CLEAR, IDLE, LOAD.
- Reset (`reset_n`=0 at a clock edge) → CLEAR, clear counter=0. All outputs 0 during and after reset, except `busy`=1.
- CLEAR: writes 0 to one word per cycle, bank-major (bank 0 words 0..DEPTH-1, then bank 1, ...); takes exactly BANKS×DEPTH cycles, then IDLE. `fetch_req` and `load_start` are ignored; `load_ready`=0.
- IDLE: `load_start`=1 latches `load_bank`, `load_base` into the write pointer → LOAD. A `load_start` with `load_base` ≥ DEPTH is ignored.
- LOAD: `load_ready`=1. On a cycle with `load_valid & load_ready`, write `load_data` to `mem[bank][ptr]` and increment `ptr`.
  - Accepted word with `load_last`=1 → IDLE, `load_done` pulses next cycle.
  - Accepted word at `ptr`=DEPTH-1 with `load_last`=0 → IDLE, `load_done` and `load_trunc` pulse next cycle. The pointer never wraps.
  - `load_start` during LOAD is ignored.
- Fetch, honoured in IDLE and LOAD: next cycle `fetch_valid`=1 and `fetch_data`=`mem[bank_sel][fetch_addr]`.
  - If `fetch_addr` ≥ DEPTH: `fetch_data` = NOP (all zeros) and `fetch_err`=1.
  - In LOAD, a fetch whose `bank_sel` equals the latched load bank is dropped: `fetch_valid`=0 next cycle. The core must hold the request while `busy`=1.
- Simultaneous `load_start` and `fetch_req` in IDLE: both are honoured. The fetch reads pre-load contents.
- Reset mid-LOAD or mid-CLEAR: abort → CLEAR, all banks re-zeroed, no `load_done`.

## Timing
- Fetch latency: 1 cycle. One fetch per cycle, fully pipelined. `fetch_valid`/`fetch_err` are 0 on every cycle not following an honoured request.
- `fetch_data` holds its last value when `fetch_valid`=0 (value 0 after reset).
- Load throughput: 1 word/cycle. A word written in cycle N is readable by a fetch issued in cycle N+1 or later (after the return to IDLE, for the same bank).
- `busy` falls in the cycle after the final CLEAR write, or in the same cycle `load_done` is asserted.
- `load_ready` is a registered state decode. No combinational path from `load_valid` to `load_ready`.

## Structure
- Package `mips_imem_pkg`: state enum {CLEAR, IDLE, LOAD}; constant `NOP_INSTR` = 32'h0000_0000.
- Sub-module `imem_bank_ram`: one bank, DEPTH×DATA_W, one synchronous write port and one registered read port. Instantiated BANKS times by generate.
- The top level holds the FSM, clear counter, write pointer, latched load bank, and fetch output register/mux.

## Test plan
- Reset with DEPTH=16, BANKS=2 → `busy`=1 for exactly 32 cycles; a fetch of bank 1 addr 15 afterwards → `fetch_valid`=1, data 0, `fetch_err`=0.
- Load bank 1 from base 4 with 3 words 0x8C01_0001, 0x0800_0002, 0x4000_0005 (last on third) → `load_done` 1 cycle after third; fetch addr 4..6 → those words at 1-cycle latency, back-to-back.
- Fetch addr 64 with DEPTH=64 → `fetch_valid`=1, `fetch_err`=1, data 0.
- Load base DEPTH-2 with 3 words, `load_last` on word 3 → only 2 accepted; `load_done` and `load_trunc` pulse; third word sees `load_ready`=0.
- During a load to bank 2: fetch bank 0 → served; fetch bank 2 → `fetch_valid`=0.
- `reset_n` low mid-load (after 2 words) → CLEAR re-entered, no `load_done`; after BANKS×DEPTH cycles, all loaded addresses read 0.
